alu_acc_sequencer: RTL and testbench

Command-driven accumulator stage that sits directly upstream of the bitwise logic units (AND/OR/XOR). It accepts one command at a time over a valid/ready handshake and presents the accumulator and operand to its bitwise unit. It writes the unit's result back into the accumulator, then returns the result and status flags over a second valid/ready handshake. It turns the combinational gate arrays into a usable, stateful ALU datapath.

---
 rtl/alu_acc_sequencer_pkg.sv | 23 ++
 rtl/alu_bitwise_unit.sv | 26 ++
 rtl/alu_acc_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_acc_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_acc_sequencer_pkg.sv
// Shared opcode, state and width definitions for the accumulator sequencer.
package alu_acc_sequencer_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOT  = 3'd5,
    OP_CLR  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_bitwise_unit.sv
// Combinational bitwise unit: AND/OR/XOR/NOT, pass-through of b, and clear.
module alu_bitwise_unit
  import alu_acc_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      OP_LOAD: y = b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      OP_CLR:  y = '0;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/alu_acc_sequencer.sv
// Command-driven accumulator stage around alu_bitwise_unit with cmd/rsp handshakes.
// Optional ALU_ACC_PARITY_EN adds a registered rsp_parity output.
module alu_acc_sequencer
  import alu_acc_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_zero,
  output logic             rsp_ones,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
`ifdef ALU_ACC_PARITY_EN
  ,
  output logic             rsp_parity
`endif
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_d, y_d, unit_y;
  logic             zero_d, ones_d;
  logic [CNT_W-1:0] cnt_d;
`ifdef ALU_ACC_PARITY_EN
  logic             parity_d;
`endif

  alu_bitwise_unit #(.WIDTH(WIDTH)) u_unit (
    .a  (acc),
    .b  (b_q),
    .op (op_q),
    .y  (unit_y)
  );

  // Next-state and next-register values
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    b_d     = b_q;
    acc_d   = acc;
    y_d     = rsp_y;
    zero_d  = rsp_zero;
    ones_d  = rsp_ones;
    cnt_d   = op_count;
`ifdef ALU_ACC_PARITY_EN
    parity_d = rsp_parity;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          b_d     = cmd_b;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        acc_d   = unit_y;
        y_d     = unit_y;
        zero_d  = (unit_y == '0);
        ones_d  = &unit_y;
`ifdef ALU_ACC_PARITY_EN
        parity_d = ^unit_y;
`endif
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          cnt_d   = op_count + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they are pure registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      b_q       <= '0;
      acc       <= '0;
      rsp_y     <= '0;
      rsp_zero  <= 1'b1;
      rsp_ones  <= 1'b0;
      op_count  <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      b_q       <= b_d;
      acc       <= acc_d;
      rsp_y     <= y_d;
      rsp_zero  <= zero_d;
      rsp_ones  <= ones_d;
      op_count  <= cnt_d;
      cmd_ready <= (state_d == ST_IDLE);
      rsp_valid <= (state_d == ST_RESP);
    end
  end

`ifdef ALU_ACC_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_parity <= 1'b0;
    else        rsp_parity <= parity_d;
  end
`endif

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Self-checking bench for alu_acc_sequencer against a behavioural accumulator model.
module tb_alu_acc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_y;
  logic       rsp_zero;
  logic       rsp_ones;
  logic [3:0] acc;
  logic [7:0] op_count;
`ifdef ALU_ACC_PARITY_EN
  logic       rsp_parity;
`endif

  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] m_acc = '0;
  logic [7:0] m_cnt = '0;
  logic [3:0] last_y;

  always #5 clk = ~clk;

  alu_acc_sequencer #(.WIDTH(4), .CNT_W(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_zero  (rsp_zero),
    .rsp_ones  (rsp_ones),
    .acc       (acc),
    .op_count  (op_count)
`ifdef ALU_ACC_PARITY_EN
    ,
    .rsp_parity(rsp_parity)
`endif
  );

  // Reference: what the accumulator becomes for a given opcode
  function automatic logic [3:0] model(input int op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      1: return b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ~a;
      6: return 4'b0000;
      default: return a;
    endcase
  endfunction

  // One command through the full handshake, with `stall` cycles of response back-pressure
  task automatic do_op(input logic [2:0] op, input logic [3:0] b, input int stall, input string name);
    logic [3:0] exp_y;
    int t;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_b = b; rsp_ready = 1'b0;
    t = 0;
    while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
    n_cmp++;
    if (!cmd_ready) begin
      n_err++; $display("FAIL %s accept_timeout: cmd_ready %b want 1", name, cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    exp_y = model(int'(op), m_acc, b);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_b = 4'($urandom);
    n_cmp++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL %s exec_hs: cmd_ready %b rsp_valid %b want 0 0", name, cmd_ready, rsp_valid);
    end
    @(posedge clk); #1;
    last_y = rsp_y;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_y !== exp_y || acc !== exp_y ||
        rsp_zero !== (exp_y == 4'b0) || rsp_ones !== (exp_y == 4'hf)) begin
      n_err++;
      $display("FAIL %s resp: valid %b y %h acc %h z %b o %b want 1 %h %h %b %b", name,
               rsp_valid, rsp_y, acc, rsp_zero, rsp_ones, exp_y, exp_y, exp_y == 4'b0, exp_y == 4'hf);
    end
`ifdef ALU_ACC_PARITY_EN
    n_cmp++;
    if (rsp_parity !== ^exp_y) begin
      n_err++; $display("FAIL %s parity: got %b want %b", name, rsp_parity, ^exp_y);
    end
`endif
    m_acc = exp_y;
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'($urandom); cmd_b = 4'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_y !== exp_y || cmd_ready !== 1'b0 || acc !== exp_y) begin
        n_err++;
        $display("FAIL %s hold%0d: valid %b y %h ready %b acc %h want 1 %h 0 %h", name, i,
                 rsp_valid, rsp_y, cmd_ready, acc, exp_y, exp_y);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    m_cnt = m_cnt + 8'd1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== m_cnt || acc !== exp_y) begin
      n_err++;
      $display("FAIL %s done: valid %b ready %b cnt %0d acc %h want 0 1 %0d %h", name,
               rsp_valid, cmd_ready, op_count, acc, m_cnt, exp_y);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_b = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (acc !== 4'b0 || rsp_y !== 4'b0 || rsp_zero !== 1'b1 || rsp_ones !== 1'b0 ||
        rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset: acc %h y %h z %b o %b v %b r %b cnt %0d want 0 0 1 0 0 1 0",
               acc, rsp_y, rsp_zero, rsp_ones, rsp_valid, cmd_ready, op_count);
    end
`ifdef ALU_ACC_PARITY_EN
    n_cmp++;
    if (rsp_parity !== 1'b0) begin
      n_err++; $display("FAIL reset_parity: got %b want 0", rsp_parity);
    end
`endif
    rst_n = 1'b1;
    m_acc = '0; m_cnt = '0;
  endtask

  task automatic test_sequence();
    logic [3:0] want [6] = '{4'b1010, 4'b0010, 4'b1110, 4'b0001, 4'b1110, 4'b0000};
    logic [2:0] ops  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [3:0] bs   [6] = '{4'b1010, 4'b0110, 4'b1100, 4'b1111, 4'b0101, 4'b1011};
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], bs[i], 0, "seq");
      n_cmp++;
      if (last_y !== want[i]) begin
        n_err++; $display("FAIL seq_const%0d: y %b want %b", i, last_y, want[i]);
      end
    end
    n_cmp++;
    if (op_count !== 8'd6 || rsp_zero !== 1'b1) begin
      n_err++; $display("FAIL seq_count: cnt %0d zero %b want 6 1", op_count, rsp_zero);
    end
  endtask

  task automatic test_flags();
    do_op(3'd1, 4'b1111, 0, "flags_load");
    n_cmp++;
    if (rsp_ones !== 1'b1 || rsp_zero !== 1'b0) begin
      n_err++; $display("FAIL flags_ones: o %b z %b want 1 0", rsp_ones, rsp_zero);
    end
    do_op(3'd2, 4'b0000, 0, "flags_and");
    n_cmp++;
    if (rsp_ones !== 1'b0 || rsp_zero !== 1'b1) begin
      n_err++; $display("FAIL flags_zero: o %b z %b want 0 1", rsp_ones, rsp_zero);
    end
  endtask

  task automatic test_back_to_back();
    do_op(3'd1, 4'b0110, 5, "bp_load");
    do_op(3'd4, 4'b0011, 5, "bp_xor");
    do_op(3'd3, 4'b1000, 1, "bp_or");
  endtask

  task automatic test_reserved();
    do_op(3'd1, 4'b0101, 0, "rsv_load");
    do_op(3'd7, 4'b1010, 0, "rsv_op7");
    n_cmp++;
    if (last_y !== 4'b0101) begin
      n_err++; $display("FAIL rsv_const: y %b want 0101", last_y);
    end
    do_op(3'd0, 4'b1111, 0, "rsv_nop");
  endtask

`ifdef ALU_ACC_PARITY_EN
  task automatic test_parity();
    do_op(3'd1, 4'b1011, 0, "par_1011");
    n_cmp++;
    if (rsp_parity !== 1'b1) begin
      n_err++; $display("FAIL par_odd: got %b want 1", rsp_parity);
    end
    do_op(3'd1, 4'b1001, 0, "par_1001");
    n_cmp++;
    if (rsp_parity !== 1'b0) begin
      n_err++; $display("FAIL par_even: got %b want 0", rsp_parity);
    end
  endtask
`endif

  task automatic test_mid_reset();
    test_reset();
    do_op(3'd1, 4'b1100, 0, "mr_load");
    test_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_b = 4'b1010;
    @(posedge clk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (acc !== 4'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== 8'd0) begin
      n_err++;
      $display("FAIL midreset: acc %h v %b r %b cnt %0d want 0 0 1 0", acc, rsp_valid, cmd_ready, op_count);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || op_count !== 8'd0 || acc !== 4'b0) begin
      n_err++;
      $display("FAIL midreset_after: v %b cnt %0d acc %h want 0 0 0", rsp_valid, op_count, acc);
    end
    rsp_ready = 1'b0;
    m_acc = '0; m_cnt = '0;
  endtask

  // Random ops with random back-pressure; enough of them to wrap op_count
  task automatic test_random_wrap();
    for (int i = 0; i < 262; i++) begin
      do_op(3'($urandom), 4'($urandom), int'($urandom_range(0, 2)), "rand");
    end
    n_cmp++;
    if (op_count !== 8'd6) begin
      n_err++; $display("FAIL wrap_count: got %0d want 6", op_count);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_flags();
    test_back_to_back();
    test_reserved();
`ifdef ALU_ACC_PARITY_EN
    test_parity();
`endif
    test_mid_reset();
    test_random_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
